// File: rtl/m62_rom_loader_if.sv
`default_nettype none
// m62_rom_loader_if: hps_io download stream plus the two SDRAM toggle-handshake write ports.
// Rev 1.0
interface m62_rom_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;

  logic        port1_req;
  logic        port1_ack;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;

  logic        port2_req;
  logic        port2_ack;
  logic [22:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait,
    input  port1_req, port1_a, port1_ds, port1_d,
    output port1_ack,
    input  port2_req, port2_a, port2_ds, port2_d,
    output port2_ack
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait,
    output port1_req, port1_a, port1_ds, port1_d,
    input  port1_ack,
    output port2_req, port2_a, port2_ds, port2_d,
    input  port2_ack
  );
endinterface
`default_nettype wire

// File: rtl/m62_rom_loader.sv
`default_nettype none
// m62_rom_loader: routes hps_io ROM bytes to SDRAM ports, sound DPRAM and PROM loader.
// Rev 1.0 -- also captures core_mod/DIP bytes and owns rom_loaded and the game reset countdown.
module m62_rom_loader #(
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] RESET_CYCLES = 16'hFFFF,
  parameter int          ACK_TIMEOUT  = 255
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  m62_rom_loader_if.slave bus,
  input  logic            user_reset,
  output logic            snd_wr,
  output logic [15:0]     snd_addr,
  output logic            dl_wr,
  output logic [11:0]     dl_addr,
  output logic [7:0]      dl_data,
  output logic [7:0]      core_mod,
  output logic [7:0]      sw0,
  output logic [7:0]      sw1,
  output logic            rom_loaded,
  output logic            reset_game,
  output logic            load_err
);
  localparam int            AW        = $clog2(FIFO_DEPTH);
  localparam int            TW        = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   FIFO_HWM  = (AW+1)'(FIFO_DEPTH - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(ACK_TIMEOUT);
  localparam logic [24:0]   SND_LO    = 25'h0020000;
  localparam logic [24:0]   SND_HI    = 25'h002FFFF;
  localparam logic [24:0]   P2_BASE   = 25'h0030000;
  localparam logic [24:0]   DL_LO     = 25'h00A0000;
  localparam logic [24:0]   DL_END    = 25'h00A0920;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [32:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic [0:0]    state;
  logic [TW-1:0] timer;
  logic          need2;
  logic          skew1;
  logic          skew2;
  logic          download_q;
  logic          loading;
  logic [15:0]   rst_cnt;

  logic          rom_strobe;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          done;
  logic          timeout;
  logic [24:0]   head_addr;
  logic [7:0]    head_data;
  logic [23:0]   rebased;

  assign rom_strobe     = bus.ioctl_wr & bus.ioctl_download & (bus.ioctl_index == 8'd0);
  assign fifo_full      = (fifo_cnt == FIFO_FULL);
  assign push           = rom_strobe & ~fifo_full;
  assign pop            = (state == S_IDLE) & (fifo_cnt != '0);
  assign {head_addr, head_data} = fifo_mem[rd_ptr];
  assign rebased        = head_addr[23:0] - 24'h030000;
  assign bus.ioctl_wait = (fifo_cnt >= FIFO_HWM);

  // skew bits absorb acks abandoned on timeout so the toggle pair counts as matched
  assign done    = ((bus.port1_ack ^ skew1) == bus.port1_req) &
                   (~need2 | ((bus.port2_ack ^ skew2) == bus.port2_req));
  assign timeout = (state == S_WAIT) & ~done & (timer >= TIMER_MAX);

  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr] <= {bus.ioctl_addr, bus.ioctl_dout};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push & ~pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop & ~push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      timer         <= '0;
      need2         <= 1'b0;
      skew1         <= 1'b0;
      skew2         <= 1'b0;
      bus.port1_req <= 1'b0;
      bus.port1_a   <= '0;
      bus.port1_ds  <= '0;
      bus.port1_d   <= '0;
      bus.port2_req <= 1'b0;
      bus.port2_a   <= '0;
      bus.port2_ds  <= '0;
      bus.port2_d   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            bus.port1_a   <= head_addr[23:1];
            bus.port1_ds  <= {head_addr[0], ~head_addr[0]};
            bus.port1_d   <= {head_data, head_data};
            bus.port1_req <= ~bus.port1_req;
            need2         <= (head_addr >= P2_BASE);
            if (head_addr >= P2_BASE) begin
              bus.port2_a   <= rebased[23:1];
              bus.port2_ds  <= {rebased[0], ~rebased[0]};
              bus.port2_d   <= {head_data, head_data};
              bus.port2_req <= ~bus.port2_req;
            end
            timer <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (done) begin
            state <= S_IDLE;
          end else if (timeout) begin
            skew1 <= bus.port1_ack ^ bus.port1_req;
            if (need2) skew2 <= bus.port2_ack ^ bus.port2_req;
            state <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      snd_wr   <= 1'b0;
      snd_addr <= '0;
      dl_wr    <= 1'b0;
      dl_addr  <= '0;
      dl_data  <= '0;
      core_mod <= '0;
      sw0      <= '0;
      sw1      <= '0;
    end else begin
      snd_wr <= rom_strobe & (bus.ioctl_addr >= SND_LO) & (bus.ioctl_addr <= SND_HI);
      dl_wr  <= rom_strobe & (bus.ioctl_addr >= DL_LO) & (bus.ioctl_addr < DL_END);
      if (rom_strobe) begin
        snd_addr <= bus.ioctl_addr[15:0];
        dl_addr  <= bus.ioctl_addr[11:0];
        dl_data  <= bus.ioctl_dout;
      end
      if (bus.ioctl_wr & bus.ioctl_download) begin
        if (bus.ioctl_index == 8'd1) core_mod <= bus.ioctl_dout;
        if (bus.ioctl_index == 8'd254 && bus.ioctl_addr[24:3] == 22'd0 && bus.ioctl_addr[2:1] == 2'b00) begin
          if (bus.ioctl_addr[0]) sw1 <= bus.ioctl_dout;
          else                   sw0 <= bus.ioctl_dout;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      download_q <= 1'b0;
      loading    <= 1'b0;
      rom_loaded <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      download_q <= bus.ioctl_download;
      if (bus.ioctl_download & ~download_q & (bus.ioctl_index == 8'd0)) begin
        loading    <= 1'b1;
        rom_loaded <= 1'b0;
      end else if (loading & ~bus.ioctl_download & (fifo_cnt == '0) & (state == S_IDLE)) begin
        loading    <= 1'b0;
        rom_loaded <= 1'b1;
      end
      if ((rom_strobe & fifo_full) | timeout) load_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_cnt    <= RESET_CYCLES;
      reset_game <= 1'b1;
    end else begin
      if (user_reset | ~rom_loaded) rst_cnt <= RESET_CYCLES;
      else if (rst_cnt != 16'd0)    rst_cnt <= rst_cnt - 16'd1;
      reset_game <= (rst_cnt != 16'd0);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_m62_rom_loader.sv
`default_nettype none
// tb_m62_rom_loader: randomized ROM stream with echoing SDRAM acks, scoreboard monitor,
// plus directed DIP/core_mod, reset countdown, overflow, timeout and mid-transfer reset cases.
module tb_m62_rom_loader;
  localparam int          FIFO_DEPTH   = 4;
  localparam logic [15:0] RESET_CYCLES = 16'd16;
  localparam int          ACK_TIMEOUT  = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        user_reset = 1'b0;
  logic        snd_wr, dl_wr, rom_loaded, reset_game, load_err;
  logic [15:0] snd_addr;
  logic [11:0] dl_addr;
  logic [7:0]  dl_data, core_mod, sw0, sw1;

  m62_rom_loader_if bus();

  m62_rom_loader #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .RESET_CYCLES(RESET_CYCLES),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk_sys   (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .user_reset(user_reset),
    .snd_wr    (snd_wr),
    .snd_addr  (snd_addr),
    .dl_wr     (dl_wr),
    .dl_addr   (dl_addr),
    .dl_data   (dl_data),
    .core_mod  (core_mod),
    .sw0       (sw0),
    .sw1       (sw1),
    .rom_loaded(rom_loaded),
    .reset_game(reset_game),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [22:0] a; logic [1:0] ds; logic [15:0] d; } sd_t;
  typedef struct { logic [15:0] addr; logic [7:0] data; } side_t;

  sd_t   p1_q[$];
  sd_t   p2_q[$];
  side_t snd_q[$];
  side_t dl_q[$];
  int    t1_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  bit    ack_en = 1'b1;
  logic  p1_prev = 1'b0;
  logic  p2_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: DUT produced an output with nothing expected", name);
  endtask

  // Reference: what each accepted index-0 byte must produce on every destination.
  task automatic model_rom(input int unsigned addr, input logic [7:0] data);
    sd_t e;
    side_t s;
    int unsigned r;
    e.a  = 23'(addr / 2);
    e.ds = (addr % 2 == 1) ? 2'b10 : 2'b01;
    e.d  = {data, data};
    p1_q.push_back(e);
    if (addr >= 32'h30000) begin
      r    = addr - 32'h30000;
      e.a  = 23'(r / 2);
      e.ds = (r % 2 == 1) ? 2'b10 : 2'b01;
      p2_q.push_back(e);
    end
    s.data = data;
    if (addr >= 32'h20000 && addr <= 32'h2FFFF) begin
      s.addr = 16'(addr % 65536);
      snd_q.push_back(s);
    end
    if (addr >= 32'hA0000 && addr < 32'hA0920) begin
      s.addr = 16'(addr - 32'hA0000);
      dl_q.push_back(s);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [7:0] idx, input int unsigned addr, input logic [7:0] data, input bit obey);
    int n;
    n = 0;
    while (obey && bus.ioctl_wait === 1'b1 && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      vectors++;
      miscompares++;
      $display("FAIL ioctl_wait_stuck: high for %0d cycles, expected to drop", n);
    end
    bus.ioctl_index = idx;
    bus.ioctl_addr  = 25'(addr);
    bus.ioctl_dout  = data;
    bus.ioctl_wr    = 1'b1;
    tick();
    bus.ioctl_wr    = 1'b0;
  endtask

  task automatic rom_byte(input int unsigned addr, input logic [7:0] data);
    model_rom(addr, data);
    io_write(8'd0, addr, data, 1'b1);
  endtask

  initial begin : resp1
    int d;
    d = 0;
    bus.port1_ack = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!reset_n) begin
        bus.port1_ack = 1'b0;
        d = 0;
      end else if (ack_en && bus.port1_req !== bus.port1_ack) begin
        if (d == 0) d = int'($urandom_range(1, 4));
        else begin
          d--;
          if (d == 0) bus.port1_ack = bus.port1_req;
        end
      end
    end
  end

  initial begin : resp2
    int d;
    d = 0;
    bus.port2_ack = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!reset_n) begin
        bus.port2_ack = 1'b0;
        d = 0;
      end else if (ack_en && bus.port2_req !== bus.port2_ack) begin
        if (d == 0) d = int'($urandom_range(1, 4));
        else begin
          d--;
          if (d == 0) bus.port2_ack = bus.port2_req;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    sd_t e;
    side_t s;
    cyc++;
    if (!reset_n) begin
      p1_prev = 1'b0;
      p2_prev = 1'b0;
    end else begin
      if (bus.port1_req !== p1_prev) begin
        p1_prev = bus.port1_req;
        t1_q.push_back(cyc);
        if (p1_q.size() == 0) unexpected("port1_req");
        else begin
          e = p1_q.pop_front();
          check("port1_a", 32'(bus.port1_a), 32'(e.a));
          check("port1_ds", 32'(bus.port1_ds), 32'(e.ds));
          check("port1_d", 32'(bus.port1_d), 32'(e.d));
        end
      end
      if (bus.port2_req !== p2_prev) begin
        p2_prev = bus.port2_req;
        if (p2_q.size() == 0) unexpected("port2_req");
        else begin
          e = p2_q.pop_front();
          check("port2_a", 32'(bus.port2_a), 32'(e.a));
          check("port2_ds", 32'(bus.port2_ds), 32'(e.ds));
          check("port2_d", 32'(bus.port2_d), 32'(e.d));
        end
      end
      if (snd_wr === 1'b1) begin
        if (snd_q.size() == 0) unexpected("snd_wr");
        else begin
          s = snd_q.pop_front();
          check("snd_addr", 32'(snd_addr), 32'(s.addr));
          check("snd_data", 32'(dl_data), 32'(s.data));
        end
      end
      if (dl_wr === 1'b1) begin
        if (dl_q.size() == 0) unexpected("dl_wr");
        else begin
          s = dl_q.pop_front();
          check("dl_addr", 32'(dl_addr), 32'(s.addr));
          check("dl_data", 32'(dl_data), 32'(s.data));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          n;
    int          base;
    bit          seen;
    int unsigned a;
    logic [7:0]  dv;
    int unsigned dir_addr [6];
    logic [7:0]  dir_data [6];
    dir_addr = '{32'h0, 32'h1, 32'h30003, 32'h2ABCD, 32'hA0905, 32'hA0920};
    dir_data = '{8'hAA, 8'h55, 8'h7E, 8'h12, 8'h3C, 8'hC3};

    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_port1_req", 32'(bus.port1_req), 32'd0);
    check("rst_port2_req", 32'(bus.port2_req), 32'd0);
    check("rst_ioctl_wait", 32'(bus.ioctl_wait), 32'd0);
    check("rst_snd_wr", 32'(snd_wr), 32'd0);
    check("rst_dl_wr", 32'(dl_wr), 32'd0);
    check("rst_core_mod", 32'(core_mod), 32'd0);
    check("rst_sw0", 32'(sw0), 32'd0);
    check("rst_sw1", 32'(sw1), 32'd0);
    check("rst_rom_loaded", 32'(rom_loaded), 32'd0);
    check("rst_reset_game", 32'(reset_game), 32'd1);
    check("rst_load_err", 32'(load_err), 32'd0);
    tick();

    bus.ioctl_index = 8'd1;
    bus.ioctl_download = 1'b1;
    tick();
    io_write(8'd1, $urandom_range(0, 32'hFFFF), 8'h5A, 1'b0);
    bus.ioctl_download = 1'b0;
    tick();
    check("core_mod", 32'(core_mod), 32'h5A);

    bus.ioctl_index = 8'd254;
    bus.ioctl_download = 1'b1;
    tick();
    io_write(8'd254, 32'd0, 8'hA1, 1'b0);
    io_write(8'd254, 32'd1, 8'hB2, 1'b0);
    io_write(8'd254, 32'd2, 8'hC3, 1'b0);
    io_write(8'd254, 32'd9, 8'hD4, 1'b0);
    bus.ioctl_download = 1'b0;
    tick();
    check("sw0", 32'(sw0), 32'hA1);
    check("sw1", 32'(sw1), 32'hB2);
    check("rom_loaded_before_rom", 32'(rom_loaded), 32'd0);

    bus.ioctl_index = 8'd0;
    bus.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) rom_byte(dir_addr[i], dir_data[i]);
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0:       a = $urandom_range(0, 32'h1FFFF);
        1:       a = $urandom_range(32'h20000, 32'h2FFFF);
        2:       a = $urandom_range(32'h2FFF0, 32'h3000F);
        3:       a = $urandom_range(32'h30010, 32'hFFFFFF);
        4:       a = $urandom_range(32'hA0000, 32'hA0FFF);
        default: a = $urandom_range(32'hA0910, 32'hA092F);
      endcase
      rom_byte(a, 8'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    n = 0;
    while ((p1_q.size() + p2_q.size() + snd_q.size() + dl_q.size()) != 0 && n < 3000) begin
      tick();
      n++;
    end
    check("rom_drain_pending", 32'(p1_q.size() + p2_q.size() + snd_q.size() + dl_q.size()), 32'd0);
    check("rom_loaded_during_dl", 32'(rom_loaded), 32'd0);
    bus.ioctl_download = 1'b0;

    n = 0;
    while (rom_loaded !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rom_loaded_set", 32'(rom_loaded), 32'd1);
    n = 0;
    while (reset_game === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reset_game_fall_delay", 32'(n), 32'(RESET_CYCLES) + 32'd1);
    check("load_err_clean", 32'(load_err), 32'd0);

    tick();
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    @(negedge clk);
    n = 0;
    seen = 1'b0;
    while ((reset_game === 1'b1 || !seen) && n < 100) begin
      if (reset_game === 1'b1) seen = 1'b1;
      @(negedge clk);
      n++;
    end
    check("user_reset_rearm", 32'(seen), 32'd1);
    check("user_reset_delay", 32'(n), 32'(RESET_CYCLES) + 32'd1);

    // Acks withheld: one entry in flight plus a full FIFO are retained, the rest dropped.
    tick();
    ack_en = 1'b0;
    bus.ioctl_index = 8'd0;
    bus.ioctl_download = 1'b1;
    tick();
    check("rom_loaded_cleared", 32'(rom_loaded), 32'd0);
    base = t1_q.size();
    for (int i = 0; i < 6; i++) begin
      dv = 8'($urandom);
      if (i <= FIFO_DEPTH) model_rom(32'h100 + 32'(i), dv);
      io_write(8'd0, 32'h100 + 32'(i), dv, 1'b0);
      check("ovf_ioctl_wait", 32'(bus.ioctl_wait), 32'(i >= FIFO_DEPTH - 1));
      check("ovf_load_err", 32'(load_err), 32'(i > FIFO_DEPTH));
    end
    n = 0;
    while (t1_q.size() < base + 3 && n < 200) begin
      tick();
      n++;
    end
    check("timeout_reissues", 32'(t1_q.size() - base), 32'd3);
    if (t1_q.size() >= base + 2)
      check("timeout_interval", 32'(t1_q[base+1] - t1_q[base]), 32'(ACK_TIMEOUT + 2));
    check("timeout_load_err", 32'(load_err), 32'd1);

    reset_n = 1'b0;
    #2;
    check("midwait_rst_port1_req", 32'(bus.port1_req), 32'd0);
    check("midwait_rst_port2_req", 32'(bus.port2_req), 32'd0);
    check("midwait_rst_ioctl_wait", 32'(bus.ioctl_wait), 32'd0);
    check("midwait_rst_load_err", 32'(load_err), 32'd0);
    check("midwait_rst_reset_game", 32'(reset_game), 32'd1);
    p1_q.delete();
    p2_q.delete();
    bus.ioctl_download = 1'b0;
    ack_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    base = t1_q.size();
    repeat (40) tick();
    check("fifo_empty_after_rst", 32'(t1_q.size() - base), 32'd0);
    check("rom_loaded_after_rst", 32'(rom_loaded), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
